// File: rtl/debounce_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : debounce_pkg                                                 |
// | Description : Shared defaults and helpers for the pin-input debounce slice. |
// |               DEFAULT_SYNC_STAGES / DEFAULT_STABLE_CYCLES give the stock    |
// |               configuration; cnt_w() sizes a counter that must hold 0..n.   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package debounce_pkg;

    localparam int DEFAULT_SYNC_STAGES   = 2;
    localparam int DEFAULT_STABLE_CYCLES = 4;

    // Bits needed to represent every value in 0..n.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/sync_chain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sync_chain                                                   |
// | Description : Plain flop shift chain used as a metastability synchronizer  |
// |               for an asynchronous pin. Reusable by any pin-input stage.     |
// | Ports       : clk  - clock, all updates on posedge                         |
// |               rst  - synchronous active-high reset, clears every stage      |
// |               i_d  - raw asynchronous input                                |
// |               o_q  - synchronized output (last stage)                      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    generate
        if (STAGES < 2) begin : g_bad_stages
            $error("sync_chain: STAGES must be >= 2");
        end
    endgenerate

    // r_stage[0] is the flop that may go metastable; later stages give it
    // time to resolve before anything downstream looks at the value.
    logic [STAGES-1:0] r_stage;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage <= '0;
        end else begin
            r_stage <= {r_stage[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_stage[STAGES-1];

endmodule : sync_chain
`default_nettype wire

// File: rtl/sync_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sync_debounce                                                |
// | Description : Conditions a bouncy asynchronous pin into a clean, clock-    |
// |               synchronous level plus single-cycle rise/fall pulses.        |
// |               Synchronizer -> stability counter -> registered level/edges. |
// | Ports       : clk     - clock, all updates on posedge                      |
// |               reset   - synchronous active-high reset                      |
// |               d_async - raw asynchronous input, may glitch at any time     |
// |               q       - debounced, synchronized level                      |
// |               rise    - one-cycle pulse in the cycle q goes 0->1           |
// |               fall    - one-cycle pulse in the cycle q goes 1->0           |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module sync_debounce
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic d_async,
    output logic q,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = cnt_w(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync_stages
            $error("sync_debounce: SYNC_STAGES must be >= 2");
        end
        if (STABLE_CYCLES < 1) begin : g_bad_stable_cycles
            $error("sync_debounce: STABLE_CYCLES must be >= 1");
        end
    endgenerate

    logic             w_s;
    logic [CNT_W-1:0] r_cnt;
    logic             r_q;
    logic             r_rise;
    logic             r_fall;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync_chain (
        .clk (clk),
        .rst (reset),
        .i_d (d_async),
        .o_q (w_s)
    );

    // State is just (r_q, r_cnt): r_cnt counts consecutive cycles where the
    // synchronized input disagrees with r_q. Any agreeing cycle restarts the
    // count, so a bounce must persist STABLE_CYCLES cycles to be accepted.
    // The counter is cleared on the update, so it never passes c_CNT_LAST.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_q    <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (w_s == r_q) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_q    <= w_s;
                r_cnt  <= '0;
                // Pulses are registered alongside r_q so they line up with
                // the first cycle the new level is visible.
                r_rise <= w_s;
                r_fall <= ~w_s;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign q    = r_q;
    assign rise = r_rise;
    assign fall = r_fall;

endmodule : sync_debounce
`default_nettype wire

// File: tb/tb_sync_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sync_debounce                                             |
// | Description : Self-checking bench for sync_debounce. Two instances: stock  |
// |               parameters (2 stages, 4 stable cycles) and a 3-stage,        |
// |               1-stable-cycle build. A history-based reference model gives  |
// |               expected q/rise/fall every cycle; directed steps add fixed   |
// |               latency and glitch expectations.                             |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_sync_debounce;

    logic clk = 1'b0;
    logic reset;
    logic d_async;
    logic q_a, rise_a, fall_a;
    logic q_b, rise_b, fall_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sync_debounce #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (4)
    ) dut_a (
        .clk     (clk),
        .reset   (reset),
        .d_async (d_async),
        .q       (q_a),
        .rise    (rise_a),
        .fall    (fall_a)
    );

    sync_debounce #(
        .SYNC_STAGES   (3),
        .STABLE_CYCLES (1)
    ) dut_b (
        .clk     (clk),
        .reset   (reset),
        .d_async (d_async),
        .q       (q_b),
        .rise    (rise_b),
        .fall    (fall_b)
    );

    // Reference model: keep the raw sample history and the history of
    // synchronized samples. The synchronized value seen at an edge is the raw
    // sample taken 'stages' edges earlier. q flips when the most recent
    // 'stable' synchronized samples all disagree with q.
    typedef struct packed {
        logic [15:0] d_hist;
        logic [15:0] s_hist;
        logic        q;
        logic        rise;
        logic        fall;
    } mstate_t;

    mstate_t m_a = '0;
    mstate_t m_b = '0;

    function automatic mstate_t model_next(input mstate_t st, input logic d,
                                           input logic rst, input int stages,
                                           input int stable);
        mstate_t     n;
        logic        s;
        logic [15:0] mask;
        if (rst) begin
            n = '0;
            return n;
        end
        n        = st;
        s        = st.d_hist[stages-1];
        n.d_hist = {st.d_hist[14:0], d};
        n.s_hist = {st.s_hist[14:0], s};
        mask     = (16'd1 << stable) - 16'd1;
        n.rise   = 1'b0;
        n.fall   = 1'b0;
        if (((n.s_hist ^ {16{st.q}}) & mask) == mask) begin
            n.q    = ~st.q;
            n.rise = n.q;
            n.fall = ~n.q;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m_a = model_next(m_a, d_async, reset, 2, 4);
        m_b = model_next(m_b, d_async, reset, 3, 1);
    end

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance to the next negedge and compare both DUTs with the model.
    task automatic tick();
        @(negedge clk);
        check("model_q_a",    q_a,    m_a.q);
        check("model_rise_a", rise_a, m_a.rise);
        check("model_fall_a", fall_a, m_a.fall);
        check("model_q_b",    q_b,    m_b.q);
        check("model_rise_b", rise_b, m_b.rise);
        check("model_fall_b", fall_b, m_b.fall);
    endtask

    initial begin
        int fall_cnt;
        int run;
        logic lvl;

        // 1. Reset held 3 cycles with d_async=1, then released.
        reset   = 1'b1;
        d_async = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t1_rst_q",    q_a,    1'b0);
            check("t1_rst_rise", rise_a, 1'b0);
            check("t1_rst_fall", fall_a, 1'b0);
        end
        reset = 1'b0;
        // Edge k=1 is the first sampling edge; q follows 5 edges later.
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("t1_q_a",    q_a,    k >= 6);
            check("t1_rise_a", rise_a, k == 6);
            check("t1_q_b",    q_b,    k >= 4);
            check("t1_rise_b", rise_b, k == 4);
        end

        // 2. Bring q to 0, then a clean 0->1 step.
        d_async = 1'b0;
        repeat (8) tick();
        check("t2_pre_q", q_a, 1'b0);
        d_async = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("t2_q_a",    q_a,    k >= 6);
            check("t2_rise_a", rise_a, k == 6);
            check("t2_fall_a", fall_a, 1'b0);
            check("t2_q_b",    q_b,    k >= 4);
            check("t2_rise_b", rise_b, k == 4);
        end

        // 3. q=0, a 3-cycle high pulse must be rejected.
        d_async = 1'b0;
        repeat (8) tick();
        d_async = 1'b1;
        repeat (3) tick();
        d_async = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("t3_q_a",    q_a,    1'b0);
            check("t3_rise_a", rise_a, 1'b0);
            check("t3_fall_a", fall_a, 1'b0);
        end
        check("t3_cnt_zero", dut_a.r_cnt == '0, 1'b1);

        // 4. q=1, bounce 0,1,0,1 then steady 0: one fall at edge 10.
        d_async = 1'b1;
        repeat (8) tick();
        check("t4_pre_q", q_a, 1'b1);
        fall_cnt = 0;
        for (int k = 1; k <= 14; k++) begin
            d_async = (k <= 4) ? ((k % 2) == 0) : 1'b0;
            tick();
            if (fall_a === 1'b1) fall_cnt++;
            check("t4_q_a",    q_a,    k < 10);
            check("t4_fall_a", fall_a, k == 10);
        end
        check("t4_one_fall", fall_cnt == 1, 1'b1);

        // 5. Mismatch built to cnt=3, reset at the would-be update edge.
        d_async = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("t5_build_q", q_a, 1'b0);
        end
        check("t5_cnt3", dut_a.r_cnt == 3'd3, 1'b1);
        reset = 1'b1;
        tick();
        check("t5_q",    q_a,    1'b0);
        check("t5_rise", rise_a, 1'b0);
        check("t5_cnt0", dut_a.r_cnt == '0, 1'b1);
        // Release with d_async still high: one rise after the normal latency.
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("t5_rel_q",    q_a,    k >= 6);
            check("t5_rel_rise", rise_a, k == 6);
        end

        // Toggling every cycle: level holds, no pulses on the stock build.
        for (int k = 0; k < 20; k++) begin
            d_async = k[0];
            tick();
            check("tog_q",    q_a,    1'b1);
            check("tog_rise", rise_a, 1'b0);
            check("tog_fall", fall_a, 1'b0);
        end

        // Randomized bursts of varying length with occasional reset.
        lvl = 1'b0;
        for (int b = 0; b < 120; b++) begin
            lvl = ~lvl;
            run = $urandom_range(1, 7);
            for (int k = 0; k < run; k++) begin
                d_async = lvl;
                reset   = ($urandom_range(0, 59) == 0);
                tick();
                check("rnd_excl_a", rise_a & fall_a, 1'b0);
            end
        end
        reset = 1'b0;
        repeat (10) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_sync_debounce
`default_nettype wire
